// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states
// and small decode helpers used by the top level and the lane merger.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC0,
    S_ACC1,
    S_RESP
  } lsu_state_t;

  // Access size in bytes for a funct3 code; 0 marks an illegal code.
  function automatic logic [2:0] f3_size(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: return 3'd1;
      F3_LH, F3_LHU: return 3'd2;
      F3_LW:         return 3'd4;
      default:       return 3'd0;
    endcase
  endfunction

  function automatic logic f3_illegal(input logic [2:0] f3);
    return f3_size(f3) == 3'd0;
  endfunction

  // Natural-alignment test: halfwords on even addresses, words on multiples of 4.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3_size(f3))
      3'd2:    return off[0];
      3'd4:    return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // Sign- or zero-extend the right-aligned assembled load bytes.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] data);
    case (f3)
      F3_LB:   return {{24{data[7]}}, data[7:0]};
      F3_LH:   return {{16{data[15]}}, data[15:0]};
      F3_LBU:  return {24'h000000, data[7:0]};
      F3_LHU:  return {16'h0000, data[15:0]};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_merge.sv
// Byte-lane steering for one word access. For every memory lane it works out
// which byte of the request lives there, whether that lane takes part in this
// phase, and the store byte to place in it. Phase 0 is the word holding the
// start address; phase 1 is the following word of a boundary-crossing access.
module lsu_lane_merge
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  size,
  input  logic        phase,
  input  logic [31:0] wdata,
  output logic [3:0]  byte_en,
  output logic [31:0] bit_mask,
  output logic [31:0] store_data,
  output logic [7:0]  lane_idx
);

  genvar g;
  for (g = 0; g < 4; g++) begin : g_lane
    logic [2:0] idx;
    logic       en;

    // Request byte index carried by this lane; phase 1 continues after the
    // (4 - off) bytes already handled in phase 0.
    assign idx = phase ? (3'(g) + 3'd4 - {1'b0, off}) : (3'(g) - {1'b0, off});
    assign en  = (phase || (3'(g) >= {1'b0, off})) && (idx < size);

    assign byte_en[g]             = en;
    assign bit_mask[8*g +: 8]     = {8{en}};
    assign store_data[8*g +: 8]   = wdata[{idx[1:0], 3'b000} +: 8];
    assign lane_idx[2*g +: 2]     = idx[1:0];
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit between execute and a word-addressed data memory.
// Sub-word stores are done as read-modify-write within the access cycle,
// word-crossing accesses are split in two, and load data is extended before
// a registered one-cycle response pulse.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writeData,
  output logic        mem_memWrite,
  output logic        mem_memRead,
  input  logic [31:0] mem_readData
);

  lsu_state_t  state, next_state;

  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  funct3_q;
  logic        store_q;
  logic [31:0] bytes_q;
  logic [31:0] bytes_next;
  logic        resp_valid_q;
  logic        resp_error_q;
  logic [31:0] resp_rdata_q;

  logic        accept;
  logic        req_err;
  logic [2:0]  size;
  logic [3:0]  end_off;
  logic        crosses;
  logic        in_access;
  logic        phase;
  logic [31:0] word_base;

  logic [3:0]  byte_en;
  logic [31:0] bit_mask;
  logic [31:0] store_data;
  logic [7:0]  lane_idx;

  assign accept    = (state == S_IDLE) && req_valid;
  assign req_err   = f3_illegal(req_funct3) ||
                     (!ALLOW_MISALIGNED && is_misaligned(req_funct3, req_addr[1:0]));
  assign size      = f3_size(funct3_q);
  assign end_off   = {2'b00, addr_q[1:0]} + {1'b0, size};
  assign crosses   = end_off > 4'd4;
  assign in_access = (state == S_ACC0) || (state == S_ACC1);
  assign phase     = (state == S_ACC1);
  assign word_base = {addr_q[31:2], 2'b00};

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_error = resp_error_q;
  assign resp_rdata = resp_rdata_q;

  lsu_lane_merge u_lane_merge (
    .off        (addr_q[1:0]),
    .size       (size),
    .phase      (phase),
    .wdata      (wdata_q),
    .byte_en    (byte_en),
    .bit_mask   (bit_mask),
    .store_data (store_data),
    .lane_idx   (lane_idx)
  );

  // Next-state decode for the access sequencer.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          next_state = req_err ? S_RESP : S_ACC0;
        end
      end
      S_ACC0:  next_state = crosses ? S_ACC1 : S_RESP;
      S_ACC1:  next_state = S_RESP;
      S_RESP:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Memory port drive; held at zero in reset so no write lands on the reset edge.
  always_comb begin
    mem_address   = 32'h0;
    mem_writeData = 32'h0;
    mem_memWrite  = 1'b0;
    mem_memRead   = 1'b0;
    if (rst_n && in_access) begin
      mem_address = phase ? (word_base + 32'd4) : word_base;
      mem_memRead = 1'b1;
      if (store_q) begin
        mem_memWrite  = 1'b1;
        mem_writeData = (mem_readData & ~bit_mask) | (store_data & bit_mask);
      end
    end
  end

  // Load byte gathering: place each active memory lane at its request byte slot.
  always_comb begin
    bytes_next = bytes_q;
    if (in_access && !store_q) begin
      for (int l = 0; l < 4; l++) begin
        if (byte_en[l]) begin
          bytes_next[{lane_idx[2*l +: 2], 3'b000} +: 8] = mem_readData[8*l +: 8];
        end
      end
    end
  end

  // State, captured request, gathered bytes and the registered response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      funct3_q     <= 3'd0;
      store_q      <= 1'b0;
      bytes_q      <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      state <= next_state;
      if (accept) begin
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        funct3_q <= req_funct3;
        store_q  <= req_store;
        bytes_q  <= 32'h0;
      end else begin
        bytes_q  <= bytes_next;
      end
      resp_valid_q <= (next_state == S_RESP);
      resp_error_q <= accept && req_err;
      if ((next_state == S_RESP) && in_access && !store_q) begin
        resp_rdata_q <= load_extend(funct3_q, bytes_next);
      end else begin
        resp_rdata_q <= 32'h0;
      end
    end
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the execute stage (ALU address, rs2 data, funct3) and the word-addressed data memory.
- Converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into 32-bit word accesses:
  - read-modify-write for sub-word stores;
  - splits misaligned accesses that cross a word boundary into two word accesses;
  - sign/zero-extends load results.
- Valid/ready request handshake toward the core; registered one-cycle response pulse.

Parameters:
- ALLOW_MISALIGNED, 1, 1: word-crossing accesses are split into two accesses. 0: any misaligned access returns resp_error with no memory access.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  high only in IDLE; a request is accepted on a clk edge where req_valid && req_ready
- req_store  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I width/sign code (0 B, 1 H, 2 W, 4 BU, 5 HU)
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- resp_valid  output  1  one-cycle completion pulse (loads and stores)
- resp_rdata  output  32  extended load data; 0 for stores and errors
- resp_error  output  1  illegal funct3, or misaligned with ALLOW_MISALIGNED=0
- mem_address  output  32  word-aligned address to data memory
- mem_writeData  output  32  merged write word
- mem_memWrite  output  1  memory write enable
- mem_memRead  output  1  memory read enable
- mem_readData  input  32  combinational read data from memory

Behaviour:
- Reset (rst_n low at an edge):
  - state returns to IDLE.
  - resp_valid, resp_error, resp_rdata, and the captured request/byte registers are cleared.
  - mem_* outputs are combinationally forced to 0 while rst_n is low, so no write occurs at the reset edge, even mid-RMW.
- States: IDLE, ACC0, ACC1, RESP.
  - IDLE: req_ready=1, mem_* = 0. Acceptance captures addr, wdata, funct3, store.
    - Next state is RESP with error if funct3 ∈ {3,6,7}, or if misaligned (H with addr[0]!=0, W with addr[1:0]!=0) and ALLOW_MISALIGNED=0.
    - Otherwise next state is ACC0.
  - ACC0: mem_address = {addr[31:2],2'b00}, mem_memRead=1.
    - Load: capture bytes from lanes off..min(3, off+size-1).
    - Store: mem_memWrite=1, mem_writeData = (mem_readData & ~mask) | (shifted data & mask).
    - Next state is ACC1 if off+size > 4, else RESP.
  - ACC1: mem_address = {addr[31:2],2'b00} + 4, wrapping modulo 2^32.
    - Lanes 0..off+size-5 receive the remaining bytes.
    - Same read/merge rules as ACC0.
    - Next state is RESP.
  - RESP: resp_valid=1 for exactly one cycle.
    - resp_rdata = assembled bytes, sign-extended (funct3 0/1/2) or zero-extended (4/5).
    - Next state is IDLE, with req_ready high in the following cycle.
- Sizes and offsets:
  - size is 1/2/4 bytes; off = addr[1:0]; little-endian byte lanes.
  - A full aligned SW still asserts mem_memRead (mask = all ones).
- Latency (accept edge = end of cycle N):
  - aligned: access in N+1, resp_valid in N+2;
  - crossing: accesses in N+1 and N+2, resp_valid in N+3;
  - error: resp_valid in N+1, no mem access.
- resp_valid and resp_error are registered outputs. req_* inputs are ignored outside IDLE. Back-to-back requests need one dead cycle (RESP).

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU);
  - state enum;
  - size decode function.
- Natural sub-module: lsu_lane_merge (combinational; given off, size, and access phase, produces the byte mask, shifted store data, and lane-select for load bytes).

Test Plan:
Preload mem[0x100]=0x8899AABB and mem[0x104]=0x11223344 for all cases.
- LW 0x100 → resp_valid 2 cycles after accept, resp_rdata=0x8899AABB, one access cycle with mem_memWrite=0.
- LB 0x103 → 0xFFFFFF88. LBU 0x103 → 0x00000088. LH 0x100 → 0xFFFFAABB. LHU 0x102 → 0x00008899.
- SH 0x101, wdata=0x12345566 → single ACC0 write, mem[0x100]=0x885566BB, mem[0x104] unchanged.
- LW 0x102 (ALLOW_MISALIGNED=1) → mem_address 0x100 then 0x104, resp 3 cycles after accept, rdata=0x33448899. Same access with ALLOW_MISALIGNED=0 → resp_error=1 after 1 cycle, no mem activity.
- SW 0x103, wdata=0xDEADBEEF → mem[0x100]=0xEF99AABB, mem[0x104]=0x11DEADBE. SW 0xFFFFFFFE → second access at mem_address 0x00000000 (wrap).
- rst_n low during ACC0 of SB 0x100 → mem_memWrite=0 that cycle, memory unchanged, next cycle in IDLE with req_ready=1 and resp_valid=0. funct3=3 → resp_error=1, resp_rdata=0.
